// File: rtl/nes_multipad_poller.sv
// Polls NUM_PADS NES/SNES pads over a shared latch/clock pair; snapshot plus press/release events.
// Latency: valid 2*NUM_BITS*CLK_DIV cycles after LATCH entry; no backpressure, outputs are one-cycle strobes.
module nes_multipad_poller #(
    parameter int CLK_DIV     = 4,
    parameter int NUM_BITS    = 8,
    parameter int NUM_PADS    = 2,
    parameter int POLL_CYCLES = 200
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         poll_req,
    input  logic [NUM_PADS-1:0]          nes_data,
    output logic                         nes_latch,
    output logic                         nes_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] released,
    output logic                         valid,
    output logic                         busy
);

    localparam int W     = NUM_PADS * NUM_BITS;
    localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
    localparam int BIT_W = $clog2(NUM_BITS + 1);
    localparam int CNT_W = $clog2(POLL_CYCLES + 1);

    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [W-1:0]     samp_q, samp_d;
    logic [W-1:0]     buttons_q, buttons_d;
    logic [W-1:0]     pressed_q, pressed_d;
    logic [W-1:0]     released_q, released_d;
    logic             valid_q, valid_d;
    logic             wrap;
    logic             trigger;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        samp_d     = samp_q;
        buttons_d  = buttons_q;
        pressed_d  = '0;
        released_d = '0;
        valid_d    = 1'b0;

        wrap    = enable && (cnt_q == CNT_LAST);
        trigger = enable && (wrap || poll_req);

        if (!enable || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Requests arriving mid-poll collapse into a single deferred poll.
        if (!enable) begin
            pending_d = 1'b0;
        end else if (poll_req && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trigger || (pending_q && enable)) begin
                    state_d   = LATCH;
                    div_d     = '0;
                    pending_d = 1'b0;
                end
            end
            LATCH: begin
                if (div_q == LATCH_LAST) begin
                    for (int p = 0; p < NUM_PADS; p++) begin
                        samp_d[p*NUM_BITS] = ~nes_data[p];
                    end
                    bit_d   = BIT_W'(1);
                    div_d   = '0;
                    state_d = SHIFT_LO;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT_LO: begin
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_q == HALF_LAST) begin
                    for (int p = 0; p < NUM_PADS; p++) begin
                        samp_d[p*NUM_BITS + int'(bit_q)] = ~nes_data[p];
                    end
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        // Final bit folds straight into the snapshot so it is visible in DONE.
                        state_d    = DONE;
                        buttons_d  = samp_d;
                        pressed_d  = samp_d & ~buttons_q;
                        released_d = ~samp_d & buttons_q;
                        valid_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DONE: begin
                if (pending_q && enable) begin
                    state_d   = LATCH;
                    div_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            samp_q     <= '0;
            buttons_q  <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            samp_q     <= samp_d;
            buttons_q  <= buttons_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            valid_q    <= valid_d;
        end
    end

    assign nes_latch = (state_q == LATCH);
    assign nes_clk   = (state_q != SHIFT_LO);
    assign busy      = (state_q != IDLE);
    assign buttons   = buttons_q;
    assign pressed   = pressed_q;
    assign released  = released_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_nes_multipad_poller.sv
// Directed bench: NES build (2 pads x 8 bits) and SNES build (2 pads x 16 bits) driven by shift-register pad models.
module tb_nes_multipad_poller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable1, poll_req1, enable2, poll_req2;
    logic [1:0]  nes_data1, nes_data2;
    logic        nes_latch1, nes_clk1, valid1, busy1;
    logic        nes_latch2, nes_clk2, valid2, busy2;
    logic [15:0] buttons1, pressed1, released1;
    logic [31:0] buttons2, pressed2, released2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nes_multipad_poller #(.CLK_DIV(4), .NUM_BITS(8), .NUM_PADS(2), .POLL_CYCLES(200)) dut1 (
        .clk(clk), .reset(reset), .enable(enable1), .poll_req(poll_req1), .nes_data(nes_data1),
        .nes_latch(nes_latch1), .nes_clk(nes_clk1), .buttons(buttons1), .pressed(pressed1),
        .released(released1), .valid(valid1), .busy(busy1)
    );

    nes_multipad_poller #(.CLK_DIV(4), .NUM_BITS(16), .NUM_PADS(2), .POLL_CYCLES(1000)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .poll_req(poll_req2), .nes_data(nes_data2),
        .nes_latch(nes_latch2), .nes_clk(nes_clk2), .buttons(buttons2), .pressed(pressed2),
        .released(released2), .valid(valid2), .busy(busy2)
    );

    // Pad models: latch loads the pressed pattern, each rising serial clock shifts the next bit out (active low).
    logic [15:0] pat1 [2];
    logic [15:0] pat2 [2];
    logic [15:0] sr1 [2] = '{16'hFFFF, 16'hFFFF};
    logic [15:0] sr2 [2] = '{16'hFFFF, 16'hFFFF};
    logic        prev_clk1 = 1'b1;
    logic        prev_clk2 = 1'b1;

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (nes_latch1) sr1[p] <= pat1[p];
            else if (nes_clk1 && !prev_clk1) sr1[p] <= sr1[p] >> 1;
            if (nes_latch2) sr2[p] <= pat2[p];
            else if (nes_clk2 && !prev_clk2) sr2[p] <= sr2[p] >> 1;
        end
        prev_clk1 <= nes_clk1;
        prev_clk2 <= nes_clk2;
    end

    assign nes_data1 = {~sr1[1][0], ~sr1[0][0]};
    assign nes_data2 = {~sr2[1][0], ~sr2[0][0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_latch"}, nes_latch1, 1'b0);
        check({tag, "_clk"}, nes_clk1, 1'b1);
        check({tag, "_busy"}, busy1, 1'b0);
        check({tag, "_valid"}, valid1, 1'b0);
        check({tag, "_buttons"}, buttons1, 16'h0000);
    endtask

    // One requested poll on the NES build, checked cycle by cycle from its first LATCH cycle.
    task automatic run_poll(input string tag, input logic [15:0] exp_b, input logic [15:0] exp_p,
                            input logic [15:0] exp_r);
        int   lo_pulses;
        logic prev;
        logic exp_clk;
        lo_pulses = 0;
        prev      = 1'b1;
        enable1   = 1'b0;
        @(negedge clk);
        enable1   = 1'b1;
        poll_req1 = 1'b1;
        @(negedge clk);
        poll_req1 = 1'b0;
        for (int i = 0; i <= 65; i++) begin
            exp_clk = !((i >= 8) && (i < 64) && (((i - 8) % 8) < 4));
            check({tag, "_latch"}, nes_latch1, (i < 8));
            check({tag, "_clk"}, nes_clk1, exp_clk);
            check({tag, "_busy"}, busy1, (i <= 64));
            check({tag, "_valid"}, valid1, (i == 64));
            if (!nes_clk1 && prev) lo_pulses++;
            prev = nes_clk1;
            if (i == 64) begin
                check({tag, "_buttons"}, buttons1, exp_b);
                check({tag, "_pressed"}, pressed1, exp_p);
                check({tag, "_released"}, released1, exp_r);
            end
            if (i == 65) begin
                check({tag, "_pressed_clr"}, pressed1, 16'h0000);
                check({tag, "_released_clr"}, released1, 16'h0000);
                check({tag, "_buttons_hold"}, buttons1, exp_b);
            end
            @(negedge clk);
        end
        check({tag, "_clk_pulses"}, lo_pulses, 7);
    endtask

    initial begin
        int   rises[$];
        int   valids[$];
        int   exp_rises[4];
        int   exp_valids[4];
        int   latch_cnt;
        int   first_rise;
        int   valid_cnt;
        logic prev_latch;

        exp_rises  = '{0, 65, 199, 399};
        exp_valids = '{64, 129, 263, 463};

        reset     = 1'b1;
        enable1   = 1'b0;
        poll_req1 = 1'b0;
        enable2   = 1'b0;
        poll_req2 = 1'b0;
        pat1[0] = 16'h0000; pat1[1] = 16'h0000;
        pat2[0] = 16'h0000; pat2[1] = 16'h0000;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("rst_hold");
        end
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_rel");
        check("rst_data", nes_data1, 2'b00);

        // Pad0 buttons 0 and 2, pad1 idle.
        pat1[0] = 16'h0005; pat1[1] = 16'h0000;
        run_poll("t1", 16'h0005, 16'h0005, 16'h0000);

        // Pad0 buttons 2,3; pad1 button 0.
        pat1[0] = 16'h000C; pat1[1] = 16'h0001;
        run_poll("t2", 16'h010C, 16'h0108, 16'h0001);

        // Two merged requests during a poll, then automatic polls on interval wraps.
        enable1 = 1'b0;
        @(negedge clk);
        enable1    = 1'b1;
        poll_req1  = 1'b1;
        @(negedge clk);
        poll_req1  = 1'b0;
        prev_latch = 1'b0;
        for (int i = 0; i <= 470; i++) begin
            if (nes_latch1 && !prev_latch) rises.push_back(i);
            prev_latch = nes_latch1;
            if (valid1) valids.push_back(i);
            if (i >= 130 && i <= 198) check("t3_idle_gap", busy1, 1'b0);
            if (i == 129) begin
                check("t3_buttons", buttons1, 16'h010C);
                check("t3_pressed", pressed1, 16'h0000);
            end
            poll_req1 = (i == 10) || (i == 20);
            @(negedge clk);
        end
        poll_req1 = 1'b0;
        check("t3_rise_count", rises.size(), 4);
        check("t3_valid_count", valids.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < rises.size()) check("t3_rise_at", rises[k], exp_rises[k]);
            if (k < valids.size()) check("t3_valid_at", valids[k], exp_valids[k]);
        end

        // Disabled: no latch activity for 1000 cycles.
        enable1   = 1'b0;
        latch_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (nes_latch1) latch_cnt++;
        end
        check("t4_no_latch", latch_cnt, 0);

        // Re-enable: counter restarts from 0, first automatic LATCH 200 cycles later.
        enable1    = 1'b1;
        first_rise = -1;
        prev_latch = 1'b0;
        for (int i = 0; i <= 233; i++) begin
            if (nes_latch1 && !prev_latch && first_rise < 0) first_rise = i;
            prev_latch = nes_latch1;
            if (i < 233) @(negedge clk);
        end
        check("t4_auto_rise", first_rise, 200);

        // Now in SHIFT_LO before bit 4 of that poll; reset aborts it.
        check("t5_in_shift_lo", nes_clk1, 1'b0);
        check("t5_busy_before", busy1, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("t5_abort");
        check("t5_pressed", pressed1, 16'h0000);
        reset     = 1'b0;
        valid_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (valid1) valid_cnt++;
        end
        check("t5_no_valid", valid_cnt, 0);
        enable1 = 1'b0;

        // SNES build: pad0 bit 11, pad1 bits 0 and 15.
        pat2[0]   = 16'h0800;
        pat2[1]   = 16'h8001;
        enable2   = 1'b1;
        poll_req2 = 1'b1;
        @(negedge clk);
        poll_req2 = 1'b0;
        for (int i = 0; i <= 130; i++) begin
            check("snes_valid", valid2, (i == 128));
            check("snes_busy", busy2, (i <= 128));
            if (i == 128) begin
                check("snes_buttons", buttons2, 32'h8001_0800);
                check("snes_pressed", pressed2, 32'h8001_0800);
                check("snes_released", released2, 32'h0000_0000);
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_multipad_poller.md
Name: nes_multipad_poller

Overview:
- Parametrised successor to the single-pad NES reader.
- One FSM drives the shared latch and serial-clock lines and samples NUM_PADS serial data inputs in parallel. NUM_BITS selects NES (8) or SNES (16) framing.
- Provides a registered button snapshot, per-button pressed/released edge events and a one-cycle valid strobe.
- Polls autonomously at a fixed interval, or on request. Sits between the controller port pins and the display/game logic.

Parameters:
- CLK_DIV, 4: system clocks per half serial-clock period; must be ≥1.
- NUM_BITS, 8: bits read per pad per poll (8 = NES, 16 = SNES); must be ≥2.
- NUM_PADS, 2: number of controller data inputs, 1..4.
- POLL_CYCLES, 200: system clocks between automatic poll starts; must be ≥1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: permits polling (both automatic and requested).
- poll_req, input, 1: single-cycle request for an immediate poll.
- nes_data, input, NUM_PADS: serial data, active-low; bit p = pad p.
- nes_latch, output, 1: shared latch line, active-high.
- nes_clk, output, 1: shared serial clock, idles high.
- buttons, output, NUM_PADS*NUM_BITS: snapshot, 1 = pressed; bit p*NUM_BITS+i = i-th bit sampled from pad p.
- pressed, output, NUM_PADS*NUM_BITS: 1-cycle events, buttons newly 1.
- released, output, NUM_PADS*NUM_BITS: 1-cycle events, buttons newly 0.
- valid, output, 1: 1-cycle strobe; buttons/pressed/released updated this cycle.
- busy, output, 1: poll in progress.

Behaviour:
- Reset values:
  - nes_latch=0, nes_clk=1.
  - buttons, pressed, released = 0; valid=0; busy=0.
  - interval counter=0, pending request cleared, FSM in IDLE.
- Reset mid-poll aborts the poll; all reset values hold the cycle after reset is sampled.
- Interval counter:
  - While enable=1, counts 0..POLL_CYCLES-1 and wraps.
  - Wrap is an automatic trigger.
  - While enable=0, counter is held at 0.
- Triggers:
  - A trigger (wrap or poll_req) in IDLE moves the FSM to LATCH next cycle.
  - poll_req while busy sets one pending flag; further requests while busy are merged.
  - Automatic triggers while busy are dropped.
  - Pending flag is cleared when enable=0.
- Output levels per FSM state:
  - IDLE: latch 0, clk 1, busy 0.
  - LATCH: latch 1, clk 1, busy 1.
  - SHIFT_LO: latch 0, clk 0, busy 1.
  - SHIFT_HI: latch 0, clk 1, busy 1.
  - DONE: latch 0, clk 1, busy 1.
- FSM transitions (each state except DONE lasts a fixed number of cycles, tracked by a divider counter):
  - IDLE -> LATCH on trigger or pending.
  - LATCH lasts 2*CLK_DIV cycles. On its last cycle, bit 0 of every pad is sampled (~nes_data), then -> SHIFT_LO.
  - SHIFT_LO lasts CLK_DIV cycles, then -> SHIFT_HI.
  - SHIFT_HI lasts CLK_DIV cycles. On its last cycle, the next bit is sampled. -> SHIFT_LO until NUM_BITS-1 clock pulses have been issued, else -> DONE.
  - DONE lasts 1 cycle, then -> IDLE. If pending=1 and enable=1, go directly to LATCH next cycle instead, clearing pending.
- Poll length: 2*NUM_BITS*CLK_DIV + 1 cycles with busy=1. If LATCH first cycle is T, valid=1 exactly at T+2*NUM_BITS*CLK_DIV (DONE cycle).
- On the DONE cycle (registered outputs, all visible together):
  - buttons <= new.
  - pressed <= new & ~old.
  - released <= ~new & old.
  - valid <= 1.
- pressed, released and valid are 0 in every other cycle; buttons holds between polls.
- First poll after reset compares against old=0, so held buttons appear in pressed.
- enable falling mid-poll: current poll completes normally; no new polls start.
- Pads are sampled simultaneously; pads share timing. No per-pad presence detection.

Test Plan:
Defaults unless stated: CLK_DIV=4, NUM_BITS=8, NUM_PADS=2, POLL_CYCLES=200.
- Hold reset 3 cycles with nes_data=2'b00 -> during reset and after release: nes_latch=0, nes_clk=1, buttons=16'h0000, valid=0, busy=0.
- poll_req at cycle T-1; pad0 model returns bits 0,2 pressed; pad1 idle (all 1s).
  - Latch is high for cycles T..T+7.
  - Exactly 7 nes_clk low pulses of 4 cycles each.
  - valid=1 only at T+64, with buttons=16'h0005, pressed=16'h0005, released=16'h0000.
  - busy is high for 65 cycles.
- Next poll with pad0 = bits 2,3 pressed and pad1 = bit 0 pressed -> buttons=16'h010C, pressed=16'h0108, released=16'h0001.
- Two poll_req pulses during a busy poll -> exactly one extra poll; its LATCH starts the cycle after DONE; no third poll before the next interval wrap.
- enable=1 with no poll_req -> LATCH starts every 200 cycles. enable=0 -> no latch pulses for 1000 cycles and the counter is held.
- reset asserted in SHIFT_LO of bit 4 -> next cycle nes_latch=0, nes_clk=1, busy=0, buttons=0; no valid pulse. SNES build (NUM_BITS=16): valid at T+128, with bit 11 of pad0 mapped to buttons[11].
